// File: rtl/adc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_seq_ctrl_pkg
// Brief   : State encoding, default parameters and the sample-period helper
//           shared by the ADC sequencer and its sample timer.
// Revision: 1.0 - initial release
// ============================================================================
package adc_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'h0,
        CHECK    = 4'h1,
        CHECK_DN = 4'h2,
        CONF     = 4'h3,
        CONF_DN  = 4'h4,
        WAIT     = 4'h5,
        READ     = 4'h6,
        READ_DN  = 4'h7,
        FIFO     = 4'h8,
        FIFO_DN  = 4'h9,
        ERROR    = 4'hA
    } state_t;

    localparam int DEF_TICK_DIV = 500;
    localparam int DEF_WDOG_CYC = 65535;

    function automatic logic [31:0] smpr_period(input logic [7:0] code,
                                                input logic [31:0] div);
        return ({24'd0, code} + 32'd1) * div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_smpr_timer.sv
`default_nettype none
// ============================================================================
// Module  : adc_smpr_timer
// Brief   : Sample-period counter producing ticks, the pending-frame flag and
//           sticky/saturating overrun reporting.
// Revision: 1.0 - initial release
// ============================================================================
module adc_smpr_timer
    import adc_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [7:0]       smpr,
    input  logic             clr_pend,
    input  logic             clr_all,
    output logic             pending,
    output logic             overrun,
    output logic [CNT_W-1:0] ovr_cnt
);

    // Wide enough for 256*TICK_DIV-1, the largest terminal count.
    localparam int PER_W = $clog2(256 * TICK_DIV);

    logic [PER_W-1:0] count;
    logic [PER_W-1:0] last;
    logic             tick;

    assign tick = en && (count == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            last    <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            if (load) begin
                count <= '0;
                last  <= PER_W'(smpr_period(smpr, TICK_DIV) - 32'd1);
            end else if (en) begin
                count <= tick ? '0 : count + PER_W'(1);
            end

            // A tick in the same cycle as the consumer's clear keeps pending set.
            if (clr_all) begin
                pending <= 1'b0;
                overrun <= 1'b0;
                ovr_cnt <= '0;
            end else if (tick) begin
                pending <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                    if (ovr_cnt != '1) begin
                        ovr_cnt <= ovr_cnt + CNT_W'(1);
                    end
                end
            end else if (clr_pend) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adc_seq_ctrl
// Brief   : ADC sequencer: check -> conf once, then a read -> fifo frame per
//           sample tick. Build macro ADC_SEQ_CTRL_WDOG_EN adds a handshake
//           watchdog with an ERROR state.
// Revision: 1.0 - initial release
// ============================================================================
module adc_seq_ctrl
    import adc_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = 16
`ifdef ADC_SEQ_CTRL_WDOG_EN
    ,
    parameter int WDOG_CYC = DEF_WDOG_CYC
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       dev_smpr,
    output logic             fs_check,
    input  logic             fd_check,
    output logic             fs_conf,
    input  logic             fd_conf,
    output logic             fs_read,
    input  logic             fd_read,
    output logic             fs_fifo,
    input  logic             fd_fifo,
    output logic             busy,
    output logic             err,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic [3:0]       state_o
);

    state_t state;
    state_t next_state;
    logic   stop_lat;
    logic   start_go;
    logic   load;
    logic   take;
    logic   stop_go;
    logic   frame_done;
    logic   run_timer;
    logic   pending;

    assign run_timer = state inside {WAIT, READ, READ_DN, FIFO, FIFO_DN};
    assign busy      = (state != IDLE);
    assign state_o   = state;

`ifdef ADC_SEQ_CTRL_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            hs_state;

    assign hs_state = state inside {CHECK, CHECK_DN, CONF, CONF_DN,
                                    READ, READ_DN, FIFO, FIFO_DN};
`endif

    always_comb begin
        next_state = state;
        start_go   = 1'b0;
        load       = 1'b0;
        take       = 1'b0;
        stop_go    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:     if (start && !stop) begin
                          next_state = CHECK;
                          start_go   = 1'b1;
                      end
            CHECK:    if (fd_check)  next_state = CHECK_DN;
            CHECK_DN: if (!fd_check) next_state = CONF;
            CONF:     if (fd_conf)   next_state = CONF_DN;
            CONF_DN:  if (!fd_conf) begin
                          next_state = WAIT;
                          load       = 1'b1;
                      end
            // Stop outranks a pending frame so an early stop never starts a read.
            WAIT:     if (stop || stop_lat) begin
                          next_state = IDLE;
                          stop_go    = 1'b1;
                      end else if (pending) begin
                          next_state = READ;
                          take       = 1'b1;
                      end
            READ:     if (fd_read)   next_state = READ_DN;
            READ_DN:  if (!fd_read)  next_state = FIFO;
            FIFO:     if (fd_fifo)   next_state = FIFO_DN;
            FIFO_DN:  if (!fd_fifo) begin
                          next_state = WAIT;
                          frame_done = 1'b1;
                      end
            ERROR:    if (stop)      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
`ifdef ADC_SEQ_CTRL_WDOG_EN
        if (hs_state && (wd_cnt == WD_W'(WDOG_CYC - 1))) begin
            next_state = ERROR;
            load       = 1'b0;
            frame_done = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fs_check  <= 1'b0;
            fs_conf   <= 1'b0;
            fs_read   <= 1'b0;
            fs_fifo   <= 1'b0;
            stop_lat  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= next_state;
            fs_check <= (next_state == CHECK);
            fs_conf  <= (next_state == CONF);
            fs_read  <= (next_state == READ);
            fs_fifo  <= (next_state == FIFO);
            if (next_state == IDLE) begin
                stop_lat <= 1'b0;
            end else if (stop && (state != IDLE)) begin
                stop_lat <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ADC_SEQ_CTRL_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (next_state != state) begin
                wd_cnt <= '0;
            end else if (hs_state) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (start_go) begin
                err <= 1'b0;
            end else if (next_state == ERROR) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    adc_smpr_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (run_timer),
        .load     (load),
        .smpr     (dev_smpr),
        .clr_pend (take || stop_go),
        .clr_all  (start_go),
        .pending  (pending),
        .overrun  (overrun),
        .ovr_cnt  (ovr_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_adc_seq_ctrl
// Brief   : Directed bench for adc_seq_ctrl with a 4-phase ADC responder and
//           a frame-count scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_seq_ctrl;
    import adc_seq_ctrl_pkg::*;

    localparam int TICK_DIV = 8;
    localparam int CNT_W    = 16;
`ifdef ADC_SEQ_CTRL_WDOG_EN
    localparam int SLOW_RD  = 14;
    localparam int SLOW_FF  = 10;
`else
    localparam int SLOW_RD  = 20;
    localparam int SLOW_FF  = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [7:0]       dev_smpr = 8'd0;
    logic             fs_check, fs_conf, fs_read, fs_fifo;
    logic             fd_check = 1'b0, fd_conf = 1'b0, fd_read = 1'b0, fd_fifo = 1'b0;
    logic             busy, err, overrun;
    logic [CNT_W-1:0] frame_cnt, ovr_cnt;
    logic [3:0]       state_o;

    always #5 clk = ~clk;

    adc_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
`ifdef ADC_SEQ_CTRL_WDOG_EN
        ,
        .WDOG_CYC (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dev_smpr  (dev_smpr),
        .fs_check  (fs_check),
        .fd_check  (fd_check),
        .fs_conf   (fs_conf),
        .fd_conf   (fd_conf),
        .fs_read   (fs_read),
        .fd_read   (fd_read),
        .fs_fifo   (fs_fifo),
        .fd_fifo   (fd_fifo),
        .busy      (busy),
        .err       (err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt),
        .ovr_cnt   (ovr_cnt),
        .state_o   (state_o)
    );

    int               pass_cnt = 0;
    int               chk_cnt  = 0;
    int               cyc      = 0;
    int               dly  [4];
    int               hcnt [4];
    logic [3:0]       fd_v;
    logic [CNT_W-1:0] sb_q [$];
    int               rd_q [$];
    logic [CNT_W-1:0] exp_frames;
    logic [CNT_W-1:0] prev_fc;
    logic             prev_rd;
    logic             fs_seen, seen_chk, seen_conf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: ADC responder and monitor run on the falling edge.
    task automatic step();
        logic [3:0]       fs_v;
        logic [CNT_W-1:0] e;
        @(negedge clk);
        cyc++;
        fs_v = {fs_fifo, fs_read, fs_conf, fs_check};
        if (fs_v != 4'd0) fs_seen = 1'b1;
        if (fs_check) seen_chk = 1'b1;
        if (fs_conf) seen_conf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (fs_v[i]) begin
                if (!fd_v[i]) begin
                    hcnt[i]++;
                    if (hcnt[i] >= dly[i]) fd_v[i] = 1'b1;
                end
            end else begin
                hcnt[i] = 0;
                fd_v[i] = 1'b0;
            end
        end
        {fd_fifo, fd_read, fd_conf, fd_check} = fd_v;
        if (fs_read && !prev_rd) begin
            exp_frames++;
            sb_q.push_back(exp_frames);
            rd_q.push_back(cyc);
        end
        if (frame_cnt !== prev_fc) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            check("frame_sb", 32'(frame_cnt), 32'(e));
        end
        prev_rd = fs_read;
        prev_fc = frame_cnt;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (state_o !== s && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic assert_reset();
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        sb_q.delete();
        rd_q.delete();
        exp_frames = '0;
        prev_fc    = '0;
        prev_rd    = 1'b0;
        fd_v       = 4'd0;
        {fd_fifo, fd_read, fd_conf, fd_check} = 4'd0;
        for (int i = 0; i < 4; i++) begin
            hcnt[i] = 0;
            dly[i]  = 2;
        end
    endtask

    task automatic release_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int e_cyc;
        int n;
        int fc0;
        int nrd;

        fs_seen = 1'b0; seen_chk = 1'b0; seen_conf = 1'b0;
        assert_reset();
        release_reset();
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_ocnt", 32'(ovr_cnt), 32'd0);
        check("rst_fs", 32'({fs_fifo, fs_read, fs_conf, fs_check}), 32'd0);

        // Nominal acquisition, period = 1*8 cycles.
        dev_smpr = 8'd0;
        pulse_start();
        check("t1_check", 32'(state_o), 32'(CHECK));
        wait_state(WAIT, 100, "t1_wait");
        e_cyc = cyc;
        check("t1_seen_chk", 32'(seen_chk), 32'd1);
        check("t1_seen_conf", 32'(seen_conf), 32'd1);
        n = 0;
        while (frame_cnt !== 16'd5 && n < 200) begin
            step();
            n++;
        end
        check("t1_frames", 32'(frame_cnt), 32'd5);
        check("t1_rd_count", 32'(rd_q.size()), 32'd5);
        check("t1_first_rd", 32'(rd_q[0] - e_cyc), 32'd9);
        for (int i = 1; i < 5; i++) check("t1_rd_gap", 32'(rd_q[i] - rd_q[i-1]), 32'd8);
        check("t1_ovr", 32'(overrun), 32'd0);

        // Asynchronous reset in the middle of a read.
        wait_state(READ, 20, "t2_read");
        assert_reset();
        check("t2_fs_read", 32'(fs_read), 32'd0);
        check("t2_state", 32'(state_o), 32'(IDLE));
        check("t2_fcnt", 32'(frame_cnt), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        release_reset();

        // One slow frame spans two further ticks.
        dly[2] = SLOW_RD;
        dly[3] = SLOW_FF;
        pulse_start();
        wait_state(FIFO_DN, 200, "t3_slow");
        dly[2] = 2;
        dly[3] = 2;
        n = 0;
        while (frame_cnt !== 16'd5 && n < 200) begin
            step();
            n++;
        end
        check("t3_frames", 32'(frame_cnt), 32'd5);
        check("t3_ovr", 32'(overrun), 32'd1);
        check("t3_ocnt", 32'(ovr_cnt), 32'd2);

        // Stop during READ_DN lets the frame finish.
        wait_state(READ_DN, 40, "t4_rddn");
        fc0 = int'(frame_cnt);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_state(IDLE, 60, "t4_idle");
        check("t4_fcnt", 32'(frame_cnt), 32'(fc0 + 1));
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_ovr_sticky", 32'(overrun), 32'd1);
        nrd = rd_q.size();
        repeat (20) step();
        check("t4_no_read", 32'(rd_q.size()), 32'(nrd));

        // Simultaneous start and stop in IDLE.
        fs_seen = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        repeat (12) step();
        check("t5_state", 32'(state_o), 32'(IDLE));
        check("t5_fs", 32'(fs_seen), 32'd0);
        check("t5_ovr", 32'(overrun), 32'd1);

        // Accepted start clears overrun; stop during CHECK ends at the first WAIT.
        pulse_start();
        check("t5b_state", 32'(state_o), 32'(CHECK));
        check("t5b_ovr", 32'(overrun), 32'd0);
        check("t5b_ocnt", 32'(ovr_cnt), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        nrd = rd_q.size();
        wait_state(IDLE, 60, "t5b_idle");
        check("t5b_no_read", 32'(rd_q.size()), 32'(nrd));

`ifdef ADC_SEQ_CTRL_WDOG_EN
        // Configure never completes: watchdog trips after 16 CONF cycles.
        dly[1] = 1000;
        pulse_start();
        wait_state(CONF, 30, "t6_conf");
        n = 0;
        while (state_o === CONF && n < 40) begin
            n++;
            step();
        end
        check("t6_conf_cyc", 32'(n), 32'd16);
        check("t6_state", 32'(state_o), 32'(ERROR));
        check("t6_err", 32'(err), 32'd1);
        check("t6_fs", 32'({fs_fifo, fs_read, fs_conf, fs_check}), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t6_idle", 32'(state_o), 32'(IDLE));
        check("t6_err_hold", 32'(err), 32'd1);
        dly[1] = 2;
        pulse_start();
        check("t6_restart", 32'(state_o), 32'(CHECK));
        check("t6_err_clr", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
